ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard over the same open-drain ps2c/ps2d lines that the keyboard receive path listens on.
- It runs the host request-to-send sequence: clock inhibit, start bit, 8 data bits LSB first, odd parity, stop bit, then checks the device ACK.
- It sits beside the keyboard translator in the keyboard/VGA/music top.
- It drives rx_inhibit so the receive path ignores the frame it is sending.

Parameters:
- INHIBIT_CYCLES, 12000: CLK cycles that ps2c is held low before the start bit (120 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000: maximum CLK cycles between consecutive device falling edges, and also from clock release to the first edge (20 ms at 100 MHz).
- FILTER_LEN, 8: number of consecutive equal samples needed before the filtered ps2c changes level.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous reset, active-low.
- start  in  1  one-cycle request to send tx_data. Sampled only in IDLE.
- tx_data  in  8  command byte. Latched on an accepted start.
- ps2c_in  in  1  raw PS/2 clock pin level.
- ps2d_in  in  1  raw PS/2 data pin level.
- ps2c_drive_low  out  1  1 = pull ps2c low; top level drives 1'b0, else 1'bz.
- ps2d_drive_low  out  1  1 = pull ps2d low; same open-drain convention.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when a transfer ends, whether it passed or failed.
- err  out  1  valid only with done: 1 = timeout or missing ACK.
- rx_inhibit  out  1  equals busy; the keyboard receiver discards bits while it is high.

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE. All outputs 0. Shift register, bit counter and timers cleared. Both lines released.
- Input conditioning: ps2c_in and ps2d_in each pass through a 2-flop synchronizer. ps2c is then filtered (FILTER_LEN equal samples). fall = filtered ps2c goes 1 to 0, a one-cycle strobe.
- Frame: frame[10:0] = {stop=1, parity=~^tx_data, tx_data[7:0], start=0}. It is latched on the cycle start is accepted.
- IDLE: busy=0. If start=1, latch the frame and go to INHIBIT. start in any other state is ignored.
- INHIBIT: ps2c_drive_low=1 for exactly INHIBIT_CYCLES cycles. On the last cycle assert ps2d_drive_low=1 (start bit), then go to RELEASE.
- RELEASE: ps2c_drive_low=0. ps2d_drive_low stays 1. Bit index=1. Wait for fall.
- DATA: on each fall, ps2d_drive_low = ~frame[index] and index increments.
  - Falls 1-8 present data bits 0-7.
  - Fall 9 presents parity.
  - Fall 10 presents stop, which releases ps2d.
  - After fall 10, go to ACK.
- ACK: on the next fall (11th), sample synchronized ps2d. 0 = ACK ok. 1 = err. Go to WAIT_IDLE.
- WAIT_IDLE: wait until filtered ps2c=1 and synced ps2d=1 for 1 cycle. Then pulse done, with err per the ACK result, and return to IDLE. busy drops in the same cycle as the done pulse.
- Timeout: a counter is cleared on entering RELEASE and on every fall. In RELEASE, DATA, ACK and WAIT_IDLE, reaching TIMEOUT_CYCLES does all of the following:
  - releases both lines immediately;
  - pulses done=1 with err=1;
  - returns to IDLE.
- Lines are never both driven low outside the INHIBIT→RELEASE boundary. Once RELEASE is entered, ps2c_drive_low=0 always.
- Reset mid-frame releases both lines asynchronously. No done pulse is produced.
- Simultaneous start and done: start is ignored, because the block is not yet in IDLE.
- Glitches on ps2c shorter than FILTER_LEN cycles produce no fall.
- Latency: first line activity (ps2c low) appears 1 cycle after start. done appears 1 cycle after idle lines are detected.

Decomposition:
- Shared package ps2_pkg holds:
  - the state encoding (IDLE, INHIBIT, RELEASE, DATA, ACK, WAIT_IDLE);
  - command constants PS2_CMD_SET_LED=8'hED, PS2_CMD_ENABLE=8'hF4, PS2_CMD_RESET=8'hFF, PS2_ACK_BYTE=8'hFA.
- One natural sub-module: ps2_line_filter, covering synchronizer, glitch filter and fall detect. The receiver path shares it.

Test Plan:
All cases use INHIBIT_CYCLES=10, TIMEOUT_CYCLES=200 and FILTER_LEN=2, with a device BFM clocking at a 40-cycle period.
- start with tx_data=8'hED:
  - ps2c low for 10 cycles, then ps2d low.
  - Device samples bits 1,0,1,1,0,1,1,1 (LSB first), parity 1, stop 1.
  - BFM ACKs, so done=1, err=0, busy=0.
- start with tx_data=8'hF4: bits 0,0,1,0,1,1,1,1, parity 0. Completes with err=0.
- BFM omits the ACK (ps2d stays 1 at the 11th edge): done=1, err=1, and both drive_low=0.
- BFM stops clocking after the 4th falling edge: done=1 with err=1 exactly 200 cycles after the 4th fall, and both lines are released.
- RST pulled low during DATA: both drive_low outputs are 0 in the same cycle, busy=0, and no done pulse. The next start with 8'hFF completes with err=0.
- start re-pulsed while busy, plus 1-cycle ps2c glitches: no second frame is sent, and the bit count is unaffected.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, frame layout and
// keyboard command bytes.
package ps2_pkg;

  localparam int unsigned FRAME_W = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RELEASE,
    ST_DATA,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_e;

  // Bit 0 goes on the wire first.
  typedef struct packed {
    logic       stop_bit;
    logic       parity;
    logic [7:0] data;
    logic       start_bit;
  } ps2_frame_t;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

  function automatic ps2_frame_t make_frame(input logic [7:0] data);
    ps2_frame_t f;
    f.stop_bit  = 1'b1;
    f.parity    = ~^data;
    f.data      = data;
    f.start_bit = 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-flop synchronizers on both lines, glitch filter
// on the clock line and a one-cycle strobe on each filtered falling edge.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2c_in,
  input  logic ps2d_in,
  output logic ps2c_filt,
  output logic ps2d_sync,
  output logic ps2c_fall
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic             c_meta;
  logic             c_sync;
  logic             d_meta;
  logic [CNT_W-1:0] cnt_q;

  // Lines idle high, so the synchronizers and filter come out of reset at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_meta    <= 1'b1;
      c_sync    <= 1'b1;
      d_meta    <= 1'b1;
      ps2d_sync <= 1'b1;
      ps2c_filt <= 1'b1;
      cnt_q     <= '0;
      ps2c_fall <= 1'b0;
    end else begin
      c_meta    <= ps2c_in;
      c_sync    <= c_meta;
      d_meta    <= ps2d_in;
      ps2d_sync <= d_meta;
      ps2c_fall <= 1'b0;
      if (c_sync != ps2c_filt) begin
        if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
          ps2c_filt <= c_sync;
          ps2c_fall <= ~c_sync;
          cnt_q     <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame clocked out
// by the device, ACK check and per-edge timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_drive_low,
  output logic       ps2d_drive_low,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       rx_inhibit
);

  localparam int unsigned TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                      : TIMEOUT_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned IDX_W   = $clog2(FRAME_W);

  logic ps2c_filt;
  logic ps2d_sync;
  logic ps2c_fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_line_filter (
    .clk       (CLK),
    .rst_n     (RST),
    .ps2c_in   (ps2c_in),
    .ps2d_in   (ps2d_in),
    .ps2c_filt (ps2c_filt),
    .ps2d_sync (ps2d_sync),
    .ps2c_fall (ps2c_fall)
  );

  ps2_tx_state_e    state_q, state_d;
  ps2_frame_t       frame_q, frame_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             ack_err_q, ack_err_d;
  logic             c_low_d, d_low_d, busy_d, done_d, err_d;
  logic [FRAME_W-1:0] frame_bits;
  logic             in_frame;

  assign frame_bits = FRAME_W'(frame_q);
  assign in_frame   = (state_q == ST_RELEASE) || (state_q == ST_DATA) ||
                      (state_q == ST_ACK)     || (state_q == ST_WAIT_IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= ST_IDLE;
      frame_q        <= '0;
      idx_q          <= '0;
      tmr_q          <= '0;
      ack_err_q      <= 1'b0;
      ps2c_drive_low <= 1'b0;
      ps2d_drive_low <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      rx_inhibit     <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_q        <= frame_d;
      idx_q          <= idx_d;
      tmr_q          <= tmr_d;
      ack_err_q      <= ack_err_d;
      ps2c_drive_low <= c_low_d;
      ps2d_drive_low <= d_low_d;
      busy           <= busy_d;
      done           <= done_d;
      err            <= err_d;
      rx_inhibit     <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    idx_d     = idx_q;
    ack_err_d = ack_err_q;
    tmr_d     = ps2c_fall ? '0 : tmr_q + TMR_W'(1);
    c_low_d   = 1'b0;
    d_low_d   = ps2d_drive_low;
    busy_d    = busy;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy_d  = 1'b0;
        d_low_d = 1'b0;
        tmr_d   = '0;
        idx_d   = '0;
        if (start) begin
          frame_d   = make_frame(tx_data);
          ack_err_d = 1'b0;
          state_d   = ST_INHIBIT;
          busy_d    = 1'b1;
          c_low_d   = 1'b1;
          d_low_d   = (INHIBIT_CYCLES == 1);
        end
      end
      // Start bit overlaps only the final inhibit cycle.
      ST_INHIBIT: begin
        c_low_d = 1'b1;
        if (tmr_q == TMR_W'(INHIBIT_CYCLES - 1)) begin
          state_d = ST_RELEASE;
          c_low_d = 1'b0;
          d_low_d = 1'b1;
          tmr_d   = '0;
          idx_d   = IDX_W'(1);
        end else begin
          tmr_d   = tmr_q + TMR_W'(1);
          d_low_d = ((tmr_q + TMR_W'(1)) == TMR_W'(INHIBIT_CYCLES - 1));
        end
      end
      ST_RELEASE: begin
        if (ps2c_fall) begin
          d_low_d = ~frame_bits[1];
          idx_d   = IDX_W'(2);
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (ps2c_fall) begin
          d_low_d = ~frame_bits[idx_q];
          if (idx_q == IDX_W'(FRAME_W - 1)) state_d = ST_ACK;
          else                              idx_d   = idx_q + IDX_W'(1);
        end
      end
      ST_ACK: begin
        if (ps2c_fall) begin
          ack_err_d = ps2d_sync;
          state_d   = ST_WAIT_IDLE;
        end
      end
      ST_WAIT_IDLE: begin
        if (ps2c_filt && ps2d_sync) begin
          done_d  = 1'b1;
          err_d   = ack_err_q;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A fall restarts the edge timer, so it never coincides with a timeout.
    if (in_frame && !ps2c_fall && !done_d && (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1))) begin
      state_d = ST_IDLE;
      c_low_d = 1'b0;
      d_low_d = 1'b0;
      done_d  = 1'b1;
      err_d   = 1'b1;
      busy_d  = 1'b0;
      tmr_d   = '0;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: device BFM on the open-drain lines,
// scoreboard of expected transfer results checked on every done pulse.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH   = 10;
  localparam int TMO   = 200;
  localparam int FLEN  = 2;
  // fall seen by the FSM: 2 sync flops + FLEN filter samples + strobe register
  localparam int FALL_LAT = 2 + FLEN + 1;

  typedef struct packed {
    logic       err;
    logic       chk_bits;
    logic [9:0] bits;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       bfm_c = 1'b1;
  logic       bfm_d = 1'b1;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_drive_low, ps2d_drive_low, busy, done, err, rx_inhibit;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         fall_cyc = 0;
  int         inh_cnt = 0;
  logic [9:0] cap_bits = '0;
  exp_t       exp_q[$];
  exp_t       e;
  logic       prev_c = 1'b0;

  assign ps2c_in = bfm_c & ~ps2c_drive_low;
  assign ps2d_in = bfm_d & ~ps2d_drive_low;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .FILTER_LEN     (FLEN)
  ) dut (
    .CLK            (clk),
    .RST            (rst_n),
    .start          (start),
    .tx_data        (tx_data),
    .ps2c_in        (ps2c_in),
    .ps2d_in        (ps2d_in),
    .ps2c_drive_low (ps2c_drive_low),
    .ps2d_drive_low (ps2d_drive_low),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .rx_inhibit     (rx_inhibit)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expected result per done pulse; also counts inhibits.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && ps2c_drive_low && !prev_c) inh_cnt++;
      prev_c = ps2c_drive_low;
      if (rst_n && done) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_err", 32'(err), 32'(e.err));
          chk("done_busy", 32'(busy), 32'd0);
          chk("done_rx_inhibit", 32'(rx_inhibit), 32'd0);
          chk("done_lines", {30'd0, ps2c_drive_low, ps2d_drive_low}, 32'd0);
          if (e.chk_bits) chk("frame_bits", 32'(cap_bits), 32'(e.bits));
        end
      end
    end
  end

  task automatic send_start(input logic [7:0] d, input bit accept);
    @(posedge clk); #1;
    tx_data = d;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    chk("start_accept_c_low", 32'(ps2c_drive_low), 32'(accept));
  endtask

  // Device model: measures the inhibit, then clocks n_falls 40-cycle periods,
  // sampling ps2d at each rising edge and optionally ACKing on the 11th.
  task automatic bfm_frame(input int n_falls, input bit do_ack, input bit glitch);
    int n_c, n_ov, guard;
    n_c = 0; n_ov = 0; guard = 0;
    @(negedge clk);
    while (!ps2c_drive_low && guard < 50) begin guard++; @(negedge clk); end
    while (ps2c_drive_low && guard < 1000) begin
      n_c++;
      if (ps2d_drive_low) n_ov++;
      guard++;
      @(negedge clk);
    end
    chk("inhibit_len", 32'(n_c), 32'(INH));
    chk("start_overlap", 32'(n_ov), 32'd1);
    chk("start_bit_line", 32'(ps2d_in), 32'd0);
    cap_bits = '0;
    cyc_wait(10);
    for (int k = 1; k <= n_falls; k++) begin
      if (k == 11 && do_ack) bfm_d = 1'b0;
      bfm_c    = 1'b0;
      fall_cyc = cyc;
      cyc_wait(20);
      bfm_c = 1'b1;
      if (k <= 10) cap_bits[k-1] = ps2d_in;
      cyc_wait(10);
      if (glitch) begin
        bfm_c = 1'b0;
        cyc_wait(1);
        bfm_c = 1'b1;
        cyc_wait(9);
      end else begin
        cyc_wait(10);
      end
      bfm_d = 1'b1;
    end
  endtask

  task automatic wait_done(input int n);
    int g;
    g = 0;
    while (done_cnt < n && g < 2000) begin @(posedge clk); g++; end
    chk("done_count", 32'(done_cnt), 32'(n));
    cyc_wait(1);
  endtask

  initial begin
    int inh0;
    // Reset state
    cyc_wait(3);
    chk("rst_c_low", 32'(ps2c_drive_low), 32'd0);
    chk("rst_d_low", 32'(ps2d_drive_low), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rx_inhibit", 32'(rx_inhibit), 32'd0);
    rst_n = 1'b1;
    cyc_wait(5);

    // Set-LEDs: data 1,0,1,1,0,1,1,1 parity 1 stop 1, ACKed
    exp_q.push_back('{err: 1'b0, chk_bits: 1'b1, bits: 10'h3ED});
    send_start(PS2_CMD_SET_LED, 1'b1);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("rx_inhibit_after_start", 32'(rx_inhibit), 32'd1);
    bfm_frame(11, 1'b1, 1'b0);
    wait_done(1);

    // Enable: data 0,0,1,0,1,1,1,1 parity 0
    exp_q.push_back('{err: 1'b0, chk_bits: 1'b1, bits: 10'h2F4});
    send_start(PS2_CMD_ENABLE, 1'b1);
    bfm_frame(11, 1'b1, 1'b0);
    wait_done(2);

    // Missing ACK on 0xFA (six ones, parity 1)
    exp_q.push_back('{err: 1'b1, chk_bits: 1'b1, bits: 10'h3FA});
    send_start(PS2_ACK_BYTE, 1'b1);
    bfm_frame(11, 1'b0, 1'b0);
    wait_done(3);

    // Device stops after the 4th falling edge
    exp_q.push_back('{err: 1'b1, chk_bits: 1'b0, bits: 10'h000});
    send_start(PS2_CMD_ENABLE, 1'b1);
    bfm_frame(4, 1'b1, 1'b0);
    wait_done(4);
    chk("timeout_latency", 32'(done_cyc - fall_cyc), 32'(TMO + FALL_LAT));

    // Reset mid-DATA: after fall 2 the host drives ~bit1 of 0xED, i.e. low
    send_start(PS2_CMD_SET_LED, 1'b1);
    bfm_frame(2, 1'b1, 1'b0);
    cyc_wait(5);
    chk("pre_reset_d_low", 32'(ps2d_drive_low), 32'd1);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("reset_c_low", 32'(ps2c_drive_low), 32'd0);
    chk("reset_d_low", 32'(ps2d_drive_low), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    cyc_wait(5);
    rst_n = 1'b1;
    cyc_wait(TMO + 100);
    chk("no_done_after_reset", 32'(done_cnt), 32'd4);
    exp_q.push_back('{err: 1'b0, chk_bits: 1'b1, bits: 10'h3FF});
    send_start(PS2_CMD_RESET, 1'b1);
    bfm_frame(11, 1'b1, 1'b0);
    wait_done(5);

    // Start re-pulsed while busy, 1-cycle ps2c glitches in every high phase
    inh0 = inh_cnt;
    exp_q.push_back('{err: 1'b0, chk_bits: 1'b1, bits: 10'h3ED});
    send_start(PS2_CMD_SET_LED, 1'b1);
    fork
      bfm_frame(11, 1'b1, 1'b1);
      begin
        cyc_wait(80);
        send_start(PS2_CMD_ENABLE, 1'b0);
        cyc_wait(200);
        send_start(PS2_CMD_RESET, 1'b0);
      end
    join
    wait_done(6);
    cyc_wait(100);
    chk("single_inhibit", 32'(inh_cnt - inh0), 32'd1);
    chk("single_done", 32'(done_cnt), 32'd6);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
